// File: rtl/parking_gate_arbiter.sv
// ---------------------------------------------------------------------------
// parking_gate_arbiter
//
// Shares the single car-event interface of the parking occupancy counter
// between several entry and exit gates. One gate is served at a time: exits
// always get a strobe; entries get a strobe only when the counter reports
// space for the car's class, otherwise the gate is denied. Every strobe is
// followed by a settle window so the counter's space flags are up to date
// before the next request is sampled.
//
// Ports
//   clock                  system clock, rising edge
//   reset                  asynchronous active-low reset
//   entry_req[NUM_ENTRY]   level request per entry gate
//   entry_is_uni[NUM_ENTRY] class of waiting car (1 = university)
//   exit_req[NUM_EXIT]     level request per exit gate
//   exit_is_uni[NUM_EXIT]  class of exiting car
//   uni_is_vacated_space   counter flag: university space available
//   free_is_vacated_space  counter flag: free space available
//   entry_grant/entry_deny one-cycle pulses per entry gate
//   exit_grant             one-cycle pulse per exit gate
//   car_entered/is_uni_car_entered  entry strobe and class to the counter
//   car_exited/is_uni_car_exited    exit strobe and class to the counter
//   busy                   high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module parking_gate_arbiter #(
  parameter int NUM_ENTRY     = 2,
  parameter int NUM_EXIT      = 2,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_ENTRY-1:0] entry_req,
  input  logic [NUM_ENTRY-1:0] entry_is_uni,
  input  logic [NUM_EXIT-1:0]  exit_req,
  input  logic [NUM_EXIT-1:0]  exit_is_uni,
  input  logic                 uni_is_vacated_space,
  input  logic                 free_is_vacated_space,
  output logic [NUM_ENTRY-1:0] entry_grant,
  output logic [NUM_ENTRY-1:0] entry_deny,
  output logic [NUM_EXIT-1:0]  exit_grant,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic                 busy
);

  localparam int EW      = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam int XW      = (NUM_EXIT > 1) ? $clog2(NUM_EXIT) : 1;
  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic CLASS_ENTRY = 1'b0;
  localparam logic CLASS_EXIT  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_SETTLE,
    S_DENY
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [EW-1:0]        entry_ptr_reg, entry_ptr_next;
  logic [XW-1:0]        exit_ptr_reg, exit_ptr_next;
  logic                 last_class_reg, last_class_next;

  logic [NUM_ENTRY-1:0] entry_grant_reg, entry_grant_next;
  logic [NUM_ENTRY-1:0] entry_deny_reg, entry_deny_next;
  logic [NUM_EXIT-1:0]  exit_grant_reg, exit_grant_next;
  logic                 car_entered_reg, car_entered_next;
  logic                 uni_entered_reg, uni_entered_next;
  logic                 car_exited_reg, car_exited_next;
  logic                 uni_exited_reg, uni_exited_next;

  // Round-robin candidate search
  logic                 entry_found;
  logic [EW-1:0]        entry_sel;
  logic [EW-1:0]        entry_probe;
  logic                 exit_found;
  logic [XW-1:0]        exit_sel;
  logic [XW-1:0]        exit_probe;

  logic                 serve_exit;
  logic                 serve_entry;
  logic                 entry_cls;
  logic                 entry_space;
  logic                 sample;

  // Scan offsets from highest to lowest so the request closest to the
  // pointer is the last one written and therefore wins.
  always_comb begin
    entry_found = 1'b0;
    entry_sel   = '0;
    entry_probe = '0;
    for (int k = NUM_ENTRY - 1; k >= 0; k--) begin
      entry_probe = EW'((int'(entry_ptr_reg) + k) % NUM_ENTRY);
      if (entry_req[entry_probe]) begin
        entry_found = 1'b1;
        entry_sel   = entry_probe;
      end
    end
  end

  always_comb begin
    exit_found = 1'b0;
    exit_sel   = '0;
    exit_probe = '0;
    for (int k = NUM_EXIT - 1; k >= 0; k--) begin
      exit_probe = XW'((int'(exit_ptr_reg) + k) % NUM_EXIT);
      if (exit_req[exit_probe]) begin
        exit_found = 1'b1;
        exit_sel   = exit_probe;
      end
    end
  end

  // With both classes pending, alternate away from the class served last.
  assign serve_exit  = exit_found && (!entry_found || (last_class_reg == CLASS_ENTRY));
  assign serve_entry = entry_found && !serve_exit;
  assign entry_cls   = entry_is_uni[entry_sel];
  assign entry_space = entry_cls ? uni_is_vacated_space : free_is_vacated_space;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    entry_ptr_next   = entry_ptr_reg;
    exit_ptr_next    = exit_ptr_reg;
    last_class_next  = last_class_reg;
    entry_grant_next = '0;
    entry_deny_next  = '0;
    exit_grant_next  = '0;
    car_entered_next = car_entered_reg;
    uni_entered_next = uni_entered_reg;
    car_exited_next  = car_exited_reg;
    uni_exited_next  = uni_exited_reg;
    sample           = 1'b0;

    case (state_reg)
      S_IDLE: begin
        sample = 1'b1;
      end
      S_PULSE: begin
        if (cnt_reg == CW'(PULSE_CYCLES - 1)) begin
          state_next       = S_SETTLE;
          cnt_next         = '0;
          car_entered_next = 1'b0;
          car_exited_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_SETTLE: begin
        // The edge that ends the settle window is itself a sample edge, so
        // back-to-back cars run at PULSE_CYCLES + SETTLE_CYCLES spacing.
        if (cnt_reg == CW'(SETTLE_CYCLES - 1)) begin
          state_next       = S_IDLE;
          cnt_next         = '0;
          uni_entered_next = 1'b0;
          uni_exited_next  = 1'b0;
          sample           = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DENY: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (sample) begin
      if (serve_exit) begin
        exit_grant_next[exit_sel] = 1'b1;
        car_exited_next           = 1'b1;
        uni_exited_next           = exit_is_uni[exit_sel];
        exit_ptr_next   = (exit_sel == XW'(NUM_EXIT - 1)) ? '0 : exit_sel + XW'(1);
        last_class_next = CLASS_EXIT;
        state_next      = S_PULSE;
        cnt_next        = '0;
      end else if (serve_entry) begin
        entry_ptr_next  = (entry_sel == EW'(NUM_ENTRY - 1)) ? '0 : entry_sel + EW'(1);
        last_class_next = CLASS_ENTRY;
        cnt_next        = '0;
        if (entry_space) begin
          entry_grant_next[entry_sel] = 1'b1;
          car_entered_next            = 1'b1;
          uni_entered_next            = entry_cls;
          state_next                  = S_PULSE;
        end else begin
          entry_deny_next[entry_sel] = 1'b1;
          state_next                 = S_DENY;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      entry_ptr_reg   <= '0;
      exit_ptr_reg    <= '0;
      last_class_reg  <= CLASS_ENTRY;
      entry_grant_reg <= '0;
      entry_deny_reg  <= '0;
      exit_grant_reg  <= '0;
      car_entered_reg <= 1'b0;
      uni_entered_reg <= 1'b0;
      car_exited_reg  <= 1'b0;
      uni_exited_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      entry_ptr_reg   <= entry_ptr_next;
      exit_ptr_reg    <= exit_ptr_next;
      last_class_reg  <= last_class_next;
      entry_grant_reg <= entry_grant_next;
      entry_deny_reg  <= entry_deny_next;
      exit_grant_reg  <= exit_grant_next;
      car_entered_reg <= car_entered_next;
      uni_entered_reg <= uni_entered_next;
      car_exited_reg  <= car_exited_next;
      uni_exited_reg  <= uni_exited_next;
    end
  end

  assign entry_grant        = entry_grant_reg;
  assign entry_deny         = entry_deny_reg;
  assign exit_grant         = exit_grant_reg;
  assign car_entered        = car_entered_reg;
  assign is_uni_car_entered = uni_entered_reg;
  assign car_exited         = car_exited_reg;
  assign is_uni_car_exited  = uni_exited_reg;
  assign busy               = (state_reg != S_IDLE);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// ---------------------------------------------------------------------------
// tb_parking_gate_arbiter
//
// Directed bench for parking_gate_arbiter with default parameters
// (2 entry gates, 2 exit gates, 2 pulse cycles, 2 settle cycles).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so every observation reflects the registers updated by that edge.
// ---------------------------------------------------------------------------
module tb_parking_gate_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] entry_req;
  logic [1:0] entry_is_uni;
  logic [1:0] exit_req;
  logic [1:0] exit_is_uni;
  logic       uni_is_vacated_space;
  logic       free_is_vacated_space;
  logic [1:0] entry_grant;
  logic [1:0] entry_deny;
  logic [1:0] exit_grant;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       busy;

  int n_checks;
  int n_errors;

  parking_gate_arbiter dut (
    .clock                 (clock),
    .reset                 (reset),
    .entry_req             (entry_req),
    .entry_is_uni          (entry_is_uni),
    .exit_req              (exit_req),
    .exit_is_uni           (exit_is_uni),
    .uni_is_vacated_space  (uni_is_vacated_space),
    .free_is_vacated_space (free_is_vacated_space),
    .entry_grant           (entry_grant),
    .entry_deny            (entry_deny),
    .exit_grant            (exit_grant),
    .car_entered           (car_entered),
    .is_uni_car_entered    (is_uni_car_entered),
    .car_exited            (car_exited),
    .is_uni_car_exited     (is_uni_car_exited),
    .busy                  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, ".entry_grant"}, int'(entry_grant), 0);
    check({tag, ".entry_deny"},  int'(entry_deny), 0);
    check({tag, ".exit_grant"},  int'(exit_grant), 0);
    check({tag, ".car_entered"}, int'(car_entered), 0);
    check({tag, ".uni_entered"}, int'(is_uni_car_entered), 0);
    check({tag, ".car_exited"},  int'(car_exited), 0);
    check({tag, ".uni_exited"},  int'(is_uni_car_exited), 0);
    check({tag, ".busy"},        int'(busy), 0);
  endtask

  initial begin
    n_checks              = 0;
    n_errors              = 0;
    reset                 = 1'b0;
    entry_req             = 2'b00;
    entry_is_uni          = 2'b00;
    exit_req              = 2'b00;
    exit_is_uni           = 2'b00;
    uni_is_vacated_space  = 1'b1;
    free_is_vacated_space = 1'b1;

    // Reset state
    tick();
    tick();
    check_all_quiet("reset");
    @(negedge clock);
    reset = 1'b1;

    // Single exit from gate 1, university car
    exit_req    = 2'b10;
    exit_is_uni = 2'b10;
    tick();                                   // E
    check("exit.grant_E",   int'(exit_grant), 2);
    check("exit.strobe_E",  int'(car_exited), 1);
    check("exit.uni_E",     int'(is_uni_car_exited), 1);
    check("exit.busy_E",    int'(busy), 1);
    exit_req    = 2'b00;
    exit_is_uni = 2'b00;
    tick();                                   // E+1
    check("exit.grant_E1",  int'(exit_grant), 0);
    check("exit.strobe_E1", int'(car_exited), 1);
    tick();                                   // E+2
    check("exit.strobe_E2", int'(car_exited), 0);
    check("exit.uni_E2",    int'(is_uni_car_exited), 1);
    check("exit.busy_E2",   int'(busy), 1);
    tick();                                   // E+3
    check("exit.uni_E3",    int'(is_uni_car_exited), 1);
    tick();                                   // E+4
    check("exit.uni_E4",    int'(is_uni_car_exited), 0);
    check("exit.busy_E4",   int'(busy), 0);

    // Entry denied for lack of university space, then granted at E+2
    uni_is_vacated_space = 1'b0;
    entry_req            = 2'b01;
    entry_is_uni         = 2'b01;
    tick();                                   // E
    check("deny.deny_E",    int'(entry_deny), 1);
    check("deny.grant_E",   int'(entry_grant), 0);
    check("deny.strobe_E",  int'(car_entered), 0);
    check("deny.busy_E",    int'(busy), 1);
    entry_req = 2'b00;
    tick();                                   // E+1
    check("deny.deny_E1",   int'(entry_deny), 0);
    check("deny.strobe_E1", int'(car_entered), 0);
    entry_req            = 2'b01;
    uni_is_vacated_space = 1'b1;
    tick();                                   // E+2
    check("regrant.grant",  int'(entry_grant), 1);
    check("regrant.strobe", int'(car_entered), 1);
    check("regrant.uni",    int'(is_uni_car_entered), 1);
    entry_req = 2'b00;

    // Asynchronous reset in the middle of the pulse
    #2;
    reset = 1'b0;
    #1;
    check_all_quiet("midreset");
    entry_req    = 2'b11;
    entry_is_uni = 2'b00;
    @(negedge clock);
    reset = 1'b1;

    // Both entry gates requesting: grants alternate 0,1,0,1 from pointer 0
    for (int t = 0; t < 4; t++) begin
      tick();                                 // sample edge
      check($sformatf("rr%0d.grant", t),  int'(entry_grant), (t % 2 == 0) ? 1 : 2);
      check($sformatf("rr%0d.strobe", t), int'(car_entered), 1);
      entry_req[t % 2] = 1'b0;
      tick();
      check($sformatf("rr%0d.gap", t),    int'(entry_grant), 0);
      entry_req[t % 2] = 1'b1;
      tick();
      tick();
    end
    entry_req = 2'b00;
    tick();
    check("rr.idle_busy", int'(busy), 0);

    // Entry and exit held from reset: exit, entry, exit, entry
    reset        = 1'b0;
    entry_req    = 2'b01;
    entry_is_uni = 2'b00;
    exit_req     = 2'b01;
    exit_is_uni  = 2'b01;
    @(negedge clock);
    reset = 1'b1;
    for (int tr = 0; tr < 4; tr++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        if (c == 0) begin
          if (tr % 2 == 0) begin
            check($sformatf("mix%0d.exit_grant", tr),  int'(exit_grant), 1);
            check($sformatf("mix%0d.entry_grant", tr), int'(entry_grant), 0);
            check($sformatf("mix%0d.uni_exited", tr),  int'(is_uni_car_exited), 1);
          end else begin
            check($sformatf("mix%0d.exit_grant", tr),  int'(exit_grant), 0);
            check($sformatf("mix%0d.entry_grant", tr), int'(entry_grant), 1);
            check($sformatf("mix%0d.uni_entered", tr), int'(is_uni_car_entered), 0);
          end
          if (tr == 3) begin
            entry_req = 2'b00;
            exit_req  = 2'b00;
          end
        end
        check($sformatf("mix%0d.c%0d.overlap", tr, c), int'(car_entered & car_exited), 0);
      end
    end
    tick();
    check("mix.idle_busy", int'(busy), 0);

    // Class bit captured at sampling; later input changes are ignored
    entry_req    = 2'b10;
    entry_is_uni = 2'b10;
    tick();                                   // E
    check("cap.grant_E",  int'(entry_grant), 2);
    check("cap.uni_E",    int'(is_uni_car_entered), 1);
    entry_req    = 2'b00;
    entry_is_uni = 2'b00;
    tick();                                   // E+1
    check("cap.uni_E1",   int'(is_uni_car_entered), 1);
    check("cap.strobe_E1", int'(car_entered), 1);
    tick();                                   // E+2
    check("cap.strobe_E2", int'(car_entered), 0);
    check("cap.uni_E2",   int'(is_uni_car_entered), 1);
    tick();                                   // E+3
    tick();                                   // E+4
    check("cap.uni_E4",   int'(is_uni_car_entered), 0);

    // Free-class car denied when free space is exhausted
    free_is_vacated_space = 1'b0;
    entry_req             = 2'b01;
    entry_is_uni          = 2'b00;
    tick();
    check("fdeny.deny",   int'(entry_deny), 1);
    check("fdeny.strobe", int'(car_entered), 0);
    entry_req = 2'b00;
    tick();
    check("fdeny.deny_E1", int'(entry_deny), 0);
    tick();
    check("fdeny.busy",   int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
